// File: rtl/cl_axil_mstr.sv
// cl_axil_mstr: AXI4-Lite master; runs one register command at a time and reports data, resp, latency.
// Latency: AW/W or AR drive the cycle after cmd accept; response is presented the cycle after B/R handshake.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready; AXI valids held until accepted.
module cl_axil_mstr #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic        clk,
   input  logic        sync_rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_wr,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_wr,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_resp,
   output logic [15:0] rsp_lat,
   output logic        timeout_err,
   output logic [31:0] m_awaddr,
   output logic        m_awvalid,
   input  logic        m_awready,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   output logic        m_wvalid,
   input  logic        m_wready,
   input  logic [1:0]  m_bresp,
   input  logic        m_bvalid,
   output logic        m_bready,
   output logic [31:0] m_araddr,
   output logic        m_arvalid,
   input  logic        m_arready,
   input  logic [31:0] m_rdata,
   input  logic [1:0]  m_rresp,
   input  logic        m_rvalid,
   output logic        m_rready
);

   // Wait counter is wide enough to hold TIMEOUT_CYC itself; it parks there once reached.
   localparam int               WCW   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WCW-1:0]   C_TMO = WCW'(TIMEOUT_CYC);
   localparam logic [WCW-1:0]   C_ONE = WCW'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WR_REQ = 3'd1,
      S_WR_RSP = 3'd2,
      S_RD_REQ = 3'd3,
      S_RD_RSP = 3'd4,
      S_RSP    = 3'd5
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [31:0]     r_addr;
   logic [31:0]     r_wdata;
   logic [3:0]      r_wstrb;
   logic            r_aw_done;
   logic            r_w_done;
   logic [15:0]     r_lat_cnt;
   logic [WCW-1:0]  r_wait_cnt;

   logic            w_aw_hs;
   logic            w_w_hs;
   logic            w_b_hs;
   logic            w_ar_hs;
   logic            w_r_hs;
   logic            w_in_wait;
   logic [15:0]     w_lat_inc;

   assign w_aw_hs   = m_awvalid & m_awready;
   assign w_w_hs    = m_wvalid  & m_wready;
   assign w_b_hs    = m_bready  & m_bvalid;
   assign w_ar_hs   = m_arvalid & m_arready;
   assign w_r_hs    = m_rready  & m_rvalid;
   assign w_in_wait = (r_state == S_WR_RSP) || (r_state == S_RD_RSP);
   assign w_lat_inc = (r_lat_cnt == 16'hFFFF) ? 16'hFFFF : (r_lat_cnt + 16'd1);

   // Address/data come straight from the captured command so they stay stable while valid.
   assign m_awaddr = r_addr;
   assign m_araddr = r_addr;
   assign m_wdata  = r_wdata;
   assign m_wstrb  = r_wstrb;

   // State register
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: AW and W may complete in either order; both must be done before waiting on B
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               w_state_nxt = cmd_wr ? S_WR_REQ : S_RD_REQ;
            end
         end
         S_WR_REQ: begin
            if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
               w_state_nxt = S_WR_RSP;
            end
         end
         S_WR_RSP: begin
            if (w_b_hs) begin
               w_state_nxt = S_RSP;
            end
         end
         S_RD_REQ: begin
            if (w_ar_hs) begin
               w_state_nxt = S_RD_RSP;
            end
         end
         S_RD_RSP: begin
            if (w_r_hs) begin
               w_state_nxt = S_RSP;
            end
         end
         S_RSP: begin
            if (rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs decode from state and done flags only, so no ready->valid combinational path exists
   always_comb begin
      cmd_ready = 1'b0;
      m_awvalid = 1'b0;
      m_wvalid  = 1'b0;
      m_bready  = 1'b0;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      rsp_valid = 1'b0;
      case (r_state)
         S_IDLE:   cmd_ready = 1'b1;
         S_WR_REQ: begin
            m_awvalid = ~r_aw_done;
            m_wvalid  = ~r_w_done;
         end
         S_WR_RSP: m_bready  = 1'b1;
         S_RD_REQ: m_arvalid = 1'b1;
         S_RD_RSP: m_rready  = 1'b1;
         S_RSP:    rsp_valid = 1'b1;
         default:  cmd_ready = 1'b0;
      endcase
   end

   // Command capture, latency and stuck-slave counters, response register
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_lat_cnt   <= '0;
         r_wait_cnt  <= '0;
         timeout_err <= 1'b0;
         rsp_wr      <= 1'b0;
         rsp_rdata   <= '0;
         rsp_resp    <= '0;
         rsp_lat     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_addr    <= cmd_addr;
                  r_wdata   <= cmd_wdata;
                  r_wstrb   <= cmd_wstrb;
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_lat_cnt <= 16'd1;
               end
            end
            S_WR_REQ: begin
               r_lat_cnt <= w_lat_inc;
               if (w_aw_hs) begin
                  r_aw_done <= 1'b1;
               end
               if (w_w_hs) begin
                  r_w_done <= 1'b1;
               end
            end
            S_WR_RSP: begin
               r_lat_cnt <= w_lat_inc;
               if (w_b_hs) begin
                  rsp_wr    <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_resp  <= m_bresp;
                  rsp_lat   <= w_lat_inc;
               end
            end
            S_RD_REQ: begin
               r_lat_cnt <= w_lat_inc;
            end
            S_RD_RSP: begin
               r_lat_cnt <= w_lat_inc;
               if (w_r_hs) begin
                  rsp_wr    <= 1'b0;
                  rsp_rdata <= m_rdata;
                  rsp_resp  <= m_rresp;
                  rsp_lat   <= w_lat_inc;
               end
            end
            default: begin
               r_lat_cnt <= r_lat_cnt;
            end
         endcase

         // Count cycles spent waiting without a response; the flag is sticky, the wait continues
         if (w_in_wait && !(w_b_hs || w_r_hs)) begin
            if (r_wait_cnt != C_TMO) begin
               r_wait_cnt <= r_wait_cnt + C_ONE;
            end
            if ((r_wait_cnt + C_ONE) == C_TMO) begin
               timeout_err <= 1'b1;
            end
         end else begin
            r_wait_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_cl_axil_mstr.sv
// Bench for cl_axil_mstr: directed AXI-Lite scenarios plus randomized commands against a delay-based model.
// Slave responder runs on the falling edge; main sequence drives and samples 1ns after the falling edge.
// Expected latency is 3 + request-phase delay + response delay, derived from the slave delay settings.
module tb_cl_axil_mstr;

   localparam int TMO = 16;

   logic        clk;
   logic        sync_rst  = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_wr    = 1'b0;
   logic [31:0] cmd_addr  = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic        rsp_wr;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [15:0] rsp_lat;
   logic        timeout_err;
   logic [31:0] m_awaddr;
   logic        m_awvalid;
   logic        m_awready = 1'b0;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_wvalid;
   logic        m_wready  = 1'b0;
   logic [1:0]  m_bresp   = '0;
   logic        m_bvalid  = 1'b0;
   logic        m_bready;
   logic [31:0] m_araddr;
   logic        m_arvalid;
   logic        m_arready = 1'b0;
   logic [31:0] m_rdata   = '0;
   logic [1:0]  m_rresp   = '0;
   logic        m_rvalid  = 1'b0;
   logic        m_rready;

   cl_axil_mstr #(.TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .sync_rst(sync_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_lat(rsp_lat),
      .timeout_err(timeout_err),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Slave delay settings, written only by the main sequence
   int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
   logic [31:0] cfg_rdata  = '0;
   logic [1:0]  cfg_resp   = '0;

   // Slave observation state, written only by the slave process
   int          cyc = 0;
   int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
   int          aw_cyc = 0, w_cyc = 0, aw_alone = 0, proto_viol = 0;
   logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
   logic [3:0]  cap_wstrb  = '0;
   int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
   bit          got_aw = 0, got_w = 0, b_pend = 0, r_pend = 0;
   bit          aw_stall = 0, w_stall = 0, ar_stall = 0;
   logic [31:0] prv_awaddr = '0, prv_wdata = '0, prv_araddr = '0;
   logic [3:0]  prv_wstrb  = '0;

   // Behavioural AXI-Lite slave: readys after a per-channel delay, responses a fixed delay after request
   always @(negedge clk) begin
      cyc++;
      if (sync_rst) begin
         m_awready = 0; m_wready = 0; m_arready = 0;
         m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rresp = 0; m_rdata = 0;
         got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
         aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
         aw_stall = 0; w_stall = 0; ar_stall = 0;
      end else begin
         if (b_pend) begin
            m_bvalid = (b_wait >= cfg_b_dly);
            m_bresp  = cfg_resp;
            if (m_bvalid && m_bready) begin n_b++; b_pend = 0; b_wait = 0; end
            else b_wait++;
         end else begin
            m_bvalid = 0; m_bresp = 0;
         end
         if (r_pend) begin
            m_rvalid = (r_wait >= cfg_r_dly);
            m_rresp  = cfg_resp;
            m_rdata  = cfg_rdata;
            if (m_rvalid && m_rready) begin n_r++; r_pend = 0; r_wait = 0; end
            else r_wait++;
         end else begin
            m_rvalid = 0; m_rresp = 0; m_rdata = 0;
         end

         if (aw_stall && (!m_awvalid || m_awaddr !== prv_awaddr)) proto_viol++;
         if (w_stall && (!m_wvalid || m_wdata !== prv_wdata || m_wstrb !== prv_wstrb)) proto_viol++;
         if (ar_stall && (!m_arvalid || m_araddr !== prv_araddr)) proto_viol++;
         if (m_awvalid && !m_wvalid) aw_alone++;

         m_awready = m_awvalid && (aw_wait >= cfg_aw_dly);
         m_wready  = m_wvalid  && (w_wait  >= cfg_w_dly);
         m_arready = m_arvalid && (ar_wait >= cfg_ar_dly);
         aw_stall = m_awvalid && !m_awready; prv_awaddr = m_awaddr;
         w_stall  = m_wvalid  && !m_wready;  prv_wdata  = m_wdata; prv_wstrb = m_wstrb;
         ar_stall = m_arvalid && !m_arready; prv_araddr = m_araddr;

         if (m_awvalid && m_awready) begin
            n_aw++; aw_cyc = cyc; cap_awaddr = m_awaddr; got_aw = 1; aw_wait = 0;
         end else if (m_awvalid) aw_wait++;
         if (m_wvalid && m_wready) begin
            n_w++; w_cyc = cyc; cap_wdata = m_wdata; cap_wstrb = m_wstrb; got_w = 1; w_wait = 0;
         end else if (m_wvalid) w_wait++;
         if (got_aw && got_w) begin
            b_pend = 1; b_wait = 0; got_aw = 0; got_w = 0;
         end
         if (m_arvalid && m_arready) begin
            n_ar++; cap_araddr = m_araddr; r_pend = 1; r_wait = 0; ar_wait = 0;
         end else if (m_arvalid) ar_wait++;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Issue one command, wait for its response, check it against the delay model, then consume it
   task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input int hold, input string tag,
                         output int err_cyc);
      int s_aw, s_w, s_b, s_ar, s_r, s_al, cycles, lat_exp, rq, wt;
      logic        h_wr;
      logic [31:0] h_rdata;
      logic [1:0]  h_resp;
      logic [15:0] h_lat;
      err_cyc = -1;
      wt = 0;
      while (!cmd_ready && wt < 20) begin tick(); wt++; end
      chk({tag, ".idle_ready"}, cmd_ready, 1);
      s_aw = n_aw; s_w = n_w; s_b = n_b; s_ar = n_ar; s_r = n_r; s_al = aw_alone;
      cmd_valid = 1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
      tick();
      cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom;
      chk({tag, ".busy_not_ready"}, cmd_ready, 0);
      cycles = 1;
      while (!rsp_valid && cycles < 400) begin
         if (timeout_err && err_cyc < 0) err_cyc = cycles;
         tick();
         cycles++;
      end
      if (timeout_err && err_cyc < 0) err_cyc = cycles;

      rq      = wr ? ((cfg_aw_dly > cfg_w_dly) ? cfg_aw_dly : cfg_w_dly) : cfg_ar_dly;
      lat_exp = 3 + rq + (wr ? cfg_b_dly : cfg_r_dly);
      chk({tag, ".rsp_valid"}, rsp_valid, 1);
      chk({tag, ".rsp_cycle"}, cycles, lat_exp);
      chk({tag, ".rsp_wr"}, rsp_wr, wr);
      chk({tag, ".rsp_rdata"}, rsp_rdata, wr ? 32'h0 : cfg_rdata);
      chk({tag, ".rsp_resp"}, rsp_resp, cfg_resp);
      chk({tag, ".rsp_lat"}, rsp_lat, lat_exp);
      if (wr) begin
         chk({tag, ".n_aw"}, n_aw - s_aw, 1);
         chk({tag, ".n_w"}, n_w - s_w, 1);
         chk({tag, ".n_b"}, n_b - s_b, 1);
         chk({tag, ".n_ar"}, n_ar - s_ar, 0);
         chk({tag, ".awaddr"}, cap_awaddr, addr);
         chk({tag, ".wdata"}, cap_wdata, wd);
         chk({tag, ".wstrb"}, cap_wstrb, st);
         chk({tag, ".aw_alone"}, aw_alone - s_al,
             (cfg_aw_dly > cfg_w_dly) ? (cfg_aw_dly - cfg_w_dly) : 0);
      end else begin
         chk({tag, ".n_ar"}, n_ar - s_ar, 1);
         chk({tag, ".n_r"}, n_r - s_r, 1);
         chk({tag, ".n_aw"}, n_aw - s_aw, 0);
         chk({tag, ".araddr"}, cap_araddr, addr);
      end

      h_wr = rsp_wr; h_rdata = rsp_rdata; h_resp = rsp_resp; h_lat = rsp_lat;
      s_aw = n_aw + n_w + n_b + n_ar + n_r;
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, ".hold_fields"}, {rsp_valid, rsp_wr, rsp_rdata, rsp_resp, rsp_lat},
             {1'b1, h_wr, h_rdata, h_resp, h_lat});
         chk({tag, ".hold_quiet"}, {cmd_ready, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready},
             6'b0);
         chk({tag, ".hold_no_hs"}, n_aw + n_w + n_b + n_ar + n_r, s_aw);
      end
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      chk({tag, ".after_rsp"}, {rsp_valid, cmd_ready}, 2'b01);
   endtask

   initial begin
      int ec;
      bit          r_wr;
      logic [31:0] r_addr, r_wd;
      logic [3:0]  r_st;

      // Reset values
      sync_rst = 1;
      tick(); tick(); tick();
      chk("rst.cmd_ready", cmd_ready, 1);
      chk("rst.valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid}, 6'b0);
      chk("rst.timeout", timeout_err, 0);
      chk("rst.rsp_fields", {rsp_wr, rsp_rdata, rsp_resp, rsp_lat}, 51'b0);
      sync_rst = 0;
      tick();

      // Zero-wait write: AW and W in the same cycle, latency 3
      cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_resp = 2'd0; cfg_rdata = 32'hDEAD_BEEF;
      do_cmd(1, 32'h600, 32'h1, 4'hF, 0, "wr0", ec);
      chk("wr0.aw_w_same_cycle", aw_cyc, w_cyc);

      // Read with 5-cycle R delay: latency 8
      cfg_ar_dly = 0; cfg_r_dly = 5; cfg_rdata = 32'h1234_5678; cfg_resp = 2'd0;
      do_cmd(0, 32'h700, 32'h0, 4'h0, 0, "rd5", ec);

      // Late AW, immediate W: W drops first, AW held 4 extra cycles, one B
      cfg_aw_dly = 4; cfg_w_dly = 0; cfg_b_dly = 0; cfg_resp = 2'd2;
      do_cmd(1, 32'h604, 32'hA5A5_0001, 4'h3, 0, "wrlate", ec);
      chk("wrlate.w_before_aw", (w_cyc < aw_cyc), 1);

      // Response held 10 cycles with a slow read
      cfg_aw_dly = 0; cfg_ar_dly = 2; cfg_r_dly = 1; cfg_rdata = 32'h0BAD_F00D; cfg_resp = 2'd1;
      do_cmd(0, 32'h7FC, 32'h0, 4'h0, 10, "hold10", ec);

      // Randomized commands, all waits below the timeout
      for (int k = 0; k < 40; k++) begin
         cfg_aw_dly = $urandom_range(0, 4);
         cfg_w_dly  = $urandom_range(0, 4);
         cfg_ar_dly = $urandom_range(0, 4);
         cfg_b_dly  = $urandom_range(0, 8);
         cfg_r_dly  = $urandom_range(0, 8);
         cfg_rdata  = $urandom;
         cfg_resp   = 2'($urandom_range(0, 3));
         r_wr   = 1'($urandom_range(0, 1));
         r_addr = $urandom & 32'hFFFF_FFFC;
         r_wd   = $urandom;
         r_st   = 4'($urandom_range(0, 15));
         do_cmd(r_wr, r_addr, r_wd, r_st, $urandom_range(0, 3), $sformatf("rnd%0d", k), ec);
      end
      chk("rnd.no_timeout", timeout_err, 0);

      // B withheld 15 waiting cycles: just under the threshold
      cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = TMO - 1; cfg_resp = 2'd0;
      do_cmd(1, 32'h610, 32'h55, 4'hF, 0, "tmo15", ec);
      chk("tmo15.no_err", timeout_err, 0);

      // B withheld 20 cycles: flag rises after 16 waiting cycles, response still completes
      cfg_b_dly = 20;
      do_cmd(1, 32'h614, 32'h66, 4'hF, 0, "tmo20", ec);
      chk("tmo20.err_cycle", ec, 2 + TMO);
      chk("tmo20.err_sticky", timeout_err, 1);

      // Reset while waiting for R
      cfg_ar_dly = 0; cfg_r_dly = 40;
      cmd_valid = 1; cmd_wr = 0; cmd_addr = 32'h720;
      tick();
      cmd_valid = 0;
      for (int i = 0; i < 5; i++) tick();
      chk("rstmid.in_rd_rsp", {m_rready, m_arvalid}, 2'b10);
      sync_rst = 1;
      tick();
      chk("rstmid.valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid}, 6'b0);
      chk("rstmid.cmd_ready", cmd_ready, 1);
      chk("rstmid.timeout", timeout_err, 0);
      chk("rstmid.lat", rsp_lat, 0);
      sync_rst = 0;
      tick();

      // Master is usable again after the abandoned read
      cfg_r_dly = 0; cfg_rdata = 32'hCAFE_0001; cfg_resp = 2'd0;
      do_cmd(0, 32'h724, 32'h0, 4'h0, 0, "post_rst", ec);
      chk("axi_stable", proto_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
